// File: rtl/image_write_pkg.sv
// Shared types and constants for the frame-buffer write scheduler.
package image_write_pkg;

   localparam int unsigned DATA_W    = 54;
   localparam int unsigned MASK_HI   = 53;
   localparam int unsigned MASK_LO   = 50;
   localparam int unsigned FRAME_BIT = 49;
   localparam int unsigned ADDR_HI   = 48;
   localparam int unsigned ADDR_LO   = 32;
   localparam int unsigned PIXEL_HI  = 31;
   localparam int unsigned PIXEL_LO  = 0;

   localparam logic [1:0] MODE_SRC0 = 2'd0;
   localparam logic [1:0] MODE_SRC1 = 2'd1;
   localparam logic [1:0] MODE_ALT  = 2'd2;
   localparam logic [1:0] MODE_PRIO = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_RUN   = 2'd2,
      ST_ACK   = 2'd3
   } state_t;

   typedef struct packed {
      logic [3:0]  mask;
      logic        frame;
      logic [16:0] addr;
      logic [31:0] pixel;
   } beat_t;

   typedef struct packed {
      logic hit;
      logic src;
   } pick_t;

   // Source selection for the next frame; hit is low when nothing qualifies.
   function automatic pick_t pick_source(input logic [1:0] mode,
                                         input logic       req0,
                                         input logic       req1,
                                         input logic       last_owner);
      pick_t p;
      logic  other_req;
      logic  last_req;
      p         = '{hit: 1'b0, src: 1'b0};
      other_req = last_owner ? req0 : req1;
      last_req  = last_owner ? req1 : req0;
      case (mode)
         MODE_SRC0: p = '{hit: req0, src: 1'b0};
         MODE_SRC1: p = '{hit: req1, src: 1'b1};
         MODE_ALT: begin
            if (other_req)     p = '{hit: 1'b1, src: ~last_owner};
            else if (last_req) p = '{hit: 1'b1, src: last_owner};
         end
         default: begin
            if (req1)      p = '{hit: 1'b1, src: 1'b1};
            else if (req0) p = '{hit: 1'b1, src: 1'b0};
         end
      endcase
      return p;
   endfunction

endpackage

// File: rtl/image_write_mux.sv
// Steers the owner's beat stream onto the shared write port while granted.
module image_write_mux
   import image_write_pkg::*;
(
   input  logic              owner,
   input  logic              grant,
   input  logic [DATA_W-1:0] src0_dout,
   input  logic              src0_valid,
   input  logic [DATA_W-1:0] src1_dout,
   input  logic              src1_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_dout,
   output logic              out_valid,
   output logic              src0_ready,
   output logic              src1_ready
);

   always_comb begin
      out_dout   = '0;
      out_valid  = 1'b0;
      src0_ready = 1'b0;
      src1_ready = 1'b0;
      if (grant) begin
         if (owner) begin
            out_dout   = src1_dout;
            out_valid  = src1_valid;
            src1_ready = out_ready;
         end else begin
            out_dout   = src0_dout;
            out_valid  = src0_valid;
            src0_ready = out_ready;
         end
      end
   end

endmodule

// File: rtl/image_write_scheduler.sv
// Frame-level arbiter for the frame-buffer write port: picks a source per
// frame tick, runs its start/done handshake and guards it with a watchdog.
module image_write_scheduler
   import image_write_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1048576,
   parameter int unsigned CNT_W          = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [1:0]        mode,
   input  logic              frame_tick,
   input  logic              src0_req,
   input  logic              src1_req,
   output logic              src0_start,
   output logic              src1_start,
   input  logic              src0_start_ack,
   input  logic              src1_start_ack,
   input  logic              src0_done,
   input  logic              src1_done,
   output logic              src0_done_ack,
   output logic              src1_done_ack,
   input  logic [DATA_W-1:0] src0_dout,
   input  logic [DATA_W-1:0] src1_dout,
   input  logic              src0_valid,
   input  logic              src1_valid,
   output logic              src0_ready,
   output logic              src1_ready,
   output logic [DATA_W-1:0] out_dout,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              owner,
   output logic              busy,
   output logic              timeout_err,
   input  logic              err_clear,
   output logic [CNT_W-1:0]  frames_done
);

   localparam int unsigned     WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   state_t           state_q, state_n;
   logic             owner_q, owner_n;
   logic             last_owner_q, last_owner_n;
   logic             tick_pending_q, tick_pending_n;
   logic [WD_W-1:0]  wdog_q, wdog_n;
   logic [1:0]       start_q, start_n;
   logic [1:0]       done_ack_q, done_ack_n;
   logic             busy_q, busy_n;
   logic             timeout_err_q, timeout_err_n;
   logic [CNT_W-1:0] frames_done_q, frames_done_n;
   pick_t            pick_c;
   logic             owner_ack_c;
   logic             owner_done_c;
   logic             grant_c;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         owner_q        <= 1'b0;
         last_owner_q   <= 1'b1;
         tick_pending_q <= 1'b0;
         wdog_q         <= '0;
         start_q        <= '0;
         done_ack_q     <= '0;
         busy_q         <= 1'b0;
         timeout_err_q  <= 1'b0;
         frames_done_q  <= '0;
      end else begin
         state_q        <= state_n;
         owner_q        <= owner_n;
         last_owner_q   <= last_owner_n;
         tick_pending_q <= tick_pending_n;
         wdog_q         <= wdog_n;
         start_q        <= start_n;
         done_ack_q     <= done_ack_n;
         busy_q         <= busy_n;
         timeout_err_q  <= timeout_err_n;
         frames_done_q  <= frames_done_n;
      end
   end

   // Next-state and next-output logic; the watchdog abort outranks the handshake.
   always_comb begin
      state_n        = state_q;
      owner_n        = owner_q;
      last_owner_n   = last_owner_q;
      tick_pending_n = tick_pending_q | frame_tick;
      wdog_n         = wdog_q;
      start_n        = start_q;
      done_ack_n     = '0;
      frames_done_n  = frames_done_q;
      timeout_err_n  = timeout_err_q & ~err_clear;
      pick_c         = pick_source(mode, src0_req, src1_req, last_owner_q);
      owner_ack_c    = owner_q ? src1_start_ack : src0_start_ack;
      owner_done_c   = owner_q ? src1_done : src0_done;

      case (state_q)
         ST_IDLE: begin
            start_n = '0;
            if (tick_pending_q && pick_c.hit) begin
               state_n        = ST_START;
               owner_n        = pick_c.src;
               last_owner_n   = pick_c.src;
               tick_pending_n = frame_tick;
               wdog_n         = '0;
               start_n        = pick_c.src ? 2'b10 : 2'b01;
            end
         end
         ST_START, ST_RUN: begin
            wdog_n = wdog_q + WD_W'(1);
            if (wdog_q == WD_LAST) begin
               state_n       = ST_IDLE;
               start_n       = '0;
               timeout_err_n = 1'b1;
            end else if (state_q == ST_START) begin
               if (owner_ack_c) begin
                  state_n = ST_RUN;
                  start_n = '0;
               end
            end else if (owner_done_c) begin
               state_n    = ST_ACK;
               done_ack_n = owner_q ? 2'b10 : 2'b01;
            end
         end
         ST_ACK: begin
            state_n       = ST_IDLE;
            frames_done_n = frames_done_q + CNT_W'(1);
         end
         default: state_n = ST_IDLE;
      endcase

      busy_n = (state_n != ST_IDLE);
   end

   assign grant_c = (state_q == ST_START) || (state_q == ST_RUN);

   image_write_mux u_mux (
      .owner      (owner_q),
      .grant      (grant_c),
      .src0_dout  (src0_dout),
      .src0_valid (src0_valid),
      .src1_dout  (src1_dout),
      .src1_valid (src1_valid),
      .out_ready  (out_ready),
      .out_dout   (out_dout),
      .out_valid  (out_valid),
      .src0_ready (src0_ready),
      .src1_ready (src1_ready)
   );

   assign src0_start    = start_q[0];
   assign src1_start    = start_q[1];
   assign src0_done_ack = done_ack_q[0];
   assign src1_done_ack = done_ack_q[1];
   assign owner         = owner_q;
   assign busy          = busy_q;
   assign timeout_err   = timeout_err_q;
   assign frames_done   = frames_done_q;

endmodule

// File: tb/tb_image_write_scheduler.sv
// Bench for image_write_scheduler: two source models, a beat scoreboard,
// a table of arbitration vectors and hand-written corner sequences.
module tb_image_write_scheduler;
   import image_write_pkg::*;

   localparam int unsigned TO    = 64;
   localparam int unsigned CNT_W = 16;
   localparam int          NV    = 9;
   localparam int          GAP   = 40;

   typedef struct {
      logic [1:0] mode;
      logic       req0;
      logic       req1;
      int         ticks;
      logic       bp;
      int         frames;
      logic [3:0] own;
   } vec_t;

   logic              clock = 1'b0;
   logic              reset, frame_tick, src0_req, src1_req, err_clear, out_ready;
   logic [1:0]        mode;
   logic [1:0]        sack, sdone, svalid, hang;
   logic [DATA_W-1:0] sdout [2];
   logic              src0_start, src1_start, src0_done_ack, src1_done_ack;
   logic              src0_ready, src1_ready, out_valid, owner, busy, timeout_err;
   logic [DATA_W-1:0] out_dout;
   logic [CNT_W-1:0]  frames_done;

   int                ph [2];
   int                idx [2];
   int                fno [2];
   logic [1:0]        smp_start, smp_ready, smp_dack;
   logic              smp_reset;
   logic [DATA_W-1:0] exp_q [$];
   logic              owner_log [$];
   logic              busy_prev, dack_prev, bp_on;
   logic [1:0]        start_seen;
   int                dack_len, dack_total, busy_len, last_busy_len, viol;
   int                n_pass, n_total, exp_total;
   vec_t              vecs [NV];

   image_write_scheduler #(.TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)) dut (
      .clock          (clock),
      .reset          (reset),
      .mode           (mode),
      .frame_tick     (frame_tick),
      .src0_req       (src0_req),
      .src1_req       (src1_req),
      .src0_start     (src0_start),
      .src1_start     (src1_start),
      .src0_start_ack (sack[0]),
      .src1_start_ack (sack[1]),
      .src0_done      (sdone[0]),
      .src1_done      (sdone[1]),
      .src0_done_ack  (src0_done_ack),
      .src1_done_ack  (src1_done_ack),
      .src0_dout      (sdout[0]),
      .src1_dout      (sdout[1]),
      .src0_valid     (svalid[0]),
      .src1_valid     (svalid[1]),
      .src0_ready     (src0_ready),
      .src1_ready     (src1_ready),
      .out_dout       (out_dout),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .owner          (owner),
      .busy           (busy),
      .timeout_err    (timeout_err),
      .err_clear      (err_clear),
      .frames_done    (frames_done)
   );

   initial forever #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [DATA_W-1:0] mk_beat(input int s, input int f, input int i);
      beat_t b;
      b.mask  = 4'hF;
      b.frame = f[0];
      b.addr  = 17'(i);
      b.pixel = {8'(s), 8'(f), 16'(i)};
      return b;
   endfunction

   function automatic logic [25:0] ctrl_bits();
      return {src0_start, src1_start, src0_done_ack, src1_done_ack, src0_ready, src1_ready,
              out_valid, owner, busy, timeout_err, frames_done};
   endfunction

   // Negedge observer: scoreboard pops, ready invariants, owner log, pulse widths.
   task automatic monitor();
      logic dack;
      if (out_valid && out_ready) begin
         check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) check("beat_data", 64'(out_dout), 64'(exp_q.pop_front()));
      end
      if ((owner && src0_ready) || (!owner && src1_ready)) viol++;
      if (out_valid && ((owner ? src1_ready : src0_ready) != out_ready)) viol++;
      if (src0_start) start_seen[0] = 1'b1;
      if (src1_start) start_seen[1] = 1'b1;
      if (busy && !busy_prev) owner_log.push_back(owner);
      if (busy) busy_len++;
      else if (busy_prev) begin
         last_busy_len = busy_len;
         busy_len      = 0;
      end
      dack = src0_done_ack | src1_done_ack;
      if (dack) begin
         dack_len++;
         dack_total++;
      end else if (dack_prev) begin
         check("done_ack_width", 64'(dack_len), 64'd1);
         dack_len = 0;
      end
      busy_prev = busy;
      dack_prev = dack;
      smp_start = {src1_start, src0_start};
      smp_ready = {src1_ready, src0_ready};
      smp_dack  = {src1_done_ack, src0_done_ack};
      smp_reset = reset;
   endtask

   // Source behaviour: ack start, gap, four beats, hold done until acked.
   task automatic model_step();
      for (int s = 0; s < 2; s++) begin
         if (smp_reset) begin
            ph[s] = 0; idx[s] = 0; sack[s] = 1'b0; sdone[s] = 1'b0;
            svalid[s] = 1'b0; sdout[s] = '0;
         end else begin
            case (ph[s])
               0: if (smp_start[s]) begin sack[s] = 1'b1; ph[s] = 1; end
               1: begin sack[s] = 1'b0; ph[s] = 2; end
               2: begin
                  idx[s] = 0; svalid[s] = 1'b1;
                  sdout[s] = mk_beat(s, fno[s], 0);
                  exp_q.push_back(sdout[s]);
                  ph[s] = 3;
               end
               3: if (smp_ready[s]) begin
                  idx[s]++;
                  if (idx[s] == 4) begin
                     svalid[s] = 1'b0; sdout[s] = '0; fno[s]++;
                     if (!hang[s]) sdone[s] = 1'b1;
                     ph[s] = 4;
                  end else begin
                     sdout[s] = mk_beat(s, fno[s], idx[s]);
                     exp_q.push_back(sdout[s]);
                  end
               end
               4: if (smp_dack[s]) begin sdone[s] = 1'b0; ph[s] = 0; end
               default: ph[s] = 0;
            endcase
         end
      end
   endtask

   task automatic cyc();
      @(negedge clock);
      monitor();
      @(posedge clock);
      #1;
      model_step();
      out_ready = bp_on ? ~out_ready : 1'b1;
   endtask

   task automatic pulse_tick();
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
   endtask

   task automatic wait_valid(output logic found);
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         cyc();
         if (out_valid) found = 1'b1;
      end
   endtask

   initial begin
      logic [1:0] need;
      logic       found;
      int         dack_before;

      vecs[0] = '{MODE_ALT,  1'b1, 1'b1, 4, 1'b0, 4, 4'b1010};
      vecs[1] = '{MODE_SRC0, 1'b1, 1'b0, 3, 1'b0, 3, 4'b0000};
      vecs[2] = '{MODE_SRC1, 1'b1, 1'b1, 2, 1'b0, 2, 4'b0011};
      vecs[3] = '{MODE_PRIO, 1'b1, 1'b0, 1, 1'b0, 1, 4'b0000};
      vecs[4] = '{MODE_PRIO, 1'b1, 1'b1, 2, 1'b0, 2, 4'b0011};
      vecs[5] = '{MODE_SRC0, 1'b1, 1'b0, 2, 1'b1, 2, 4'b0000};
      vecs[6] = '{MODE_SRC0, 1'b0, 1'b1, 1, 1'b0, 0, 4'b0000};
      vecs[7] = '{MODE_SRC1, 1'b0, 1'b1, 0, 1'b0, 1, 4'b0001};
      vecs[8] = '{MODE_ALT,  1'b1, 1'b1, 2, 1'b1, 2, 4'b0010};

      n_pass = 0; n_total = 0; exp_total = 0; viol = 0;
      busy_prev = 1'b0; dack_prev = 1'b0; bp_on = 1'b0; start_seen = '0;
      dack_len = 0; dack_total = 0; busy_len = 0; last_busy_len = 0;
      smp_start = '0; smp_ready = '0; smp_dack = '0; smp_reset = 1'b1;
      for (int s = 0; s < 2; s++) begin ph[s] = 0; idx[s] = 0; fno[s] = 0; sdout[s] = '0; end
      reset = 1'b1; mode = MODE_SRC0; frame_tick = 1'b0; src0_req = 1'b0; src1_req = 1'b0;
      err_clear = 1'b0; out_ready = 1'b1; sack = '0; sdone = '0; svalid = '0; hang = '0;

      repeat (3) cyc();
      check("reset_ctrl", 64'(ctrl_bits()), 64'd0);
      check("reset_dout", 64'(out_dout), 64'd0);
      reset = 1'b0;
      cyc();

      for (int v = 0; v < NV; v++) begin
         mode = vecs[v].mode; src0_req = vecs[v].req0; src1_req = vecs[v].req1;
         bp_on = vecs[v].bp;
         owner_log.delete(); start_seen = '0; viol = 0;
         for (int t = 0; t < vecs[v].ticks; t++) begin
            pulse_tick();
            repeat (GAP) cyc();
         end
         repeat (GAP) cyc();
         bp_on = 1'b0;
         exp_total += vecs[v].frames;
         check($sformatf("v%0d_frames_done", v), 64'(frames_done), 64'(CNT_W'(exp_total)));
         check($sformatf("v%0d_frame_count", v), 64'(owner_log.size()), 64'(vecs[v].frames));
         need = '0;
         for (int k = 0; k < vecs[v].frames; k++) begin
            if (k < owner_log.size())
               check($sformatf("v%0d_owner%0d", v, k), 64'(owner_log[k]), 64'(vecs[v].own[k]));
            need[vecs[v].own[k]] = 1'b1;
         end
         check($sformatf("v%0d_starts_seen", v), 64'(start_seen), 64'(need));
         check($sformatf("v%0d_ready_viol", v), 64'(viol), 64'd0);
         check($sformatf("v%0d_beats_left", v), 64'(exp_q.size()), 64'd0);
         check($sformatf("v%0d_idle", v), 64'(busy), 64'd0);
      end

      // Extra ticks during a running frame collapse into one pending frame.
      mode = MODE_SRC0; src0_req = 1'b1; src1_req = 1'b0; owner_log.delete();
      pulse_tick();
      wait_valid(found);
      check("twotick_run_reached", 64'(found), 64'd1);
      pulse_tick(); cyc(); cyc(); pulse_tick();
      repeat (3 * GAP) cyc();
      exp_total += 2;
      check("twotick_frames_done", 64'(frames_done), 64'(CNT_W'(exp_total)));
      check("twotick_frame_count", 64'(owner_log.size()), 64'd2);
      check("twotick_beats_left", 64'(exp_q.size()), 64'd0);

      // Watchdog abort on a source that never reports done.
      hang[0] = 1'b1; owner_log.delete(); dack_before = dack_total;
      pulse_tick();
      repeat (120) cyc();
      check("to_err_set", 64'(timeout_err), 64'd1);
      check("to_busy_len", 64'(last_busy_len), 64'(TO));
      check("to_frames_done", 64'(frames_done), 64'(CNT_W'(exp_total)));
      check("to_no_done_ack", 64'(dack_total), 64'(dack_before));
      check("to_idle", 64'(busy), 64'd0);
      err_clear = 1'b1; cyc(); err_clear = 1'b0; cyc();
      check("to_err_cleared", 64'(timeout_err), 64'd0);
      hang = '0;

      // Reset in the middle of a running frame.
      mode = MODE_SRC1; src0_req = 1'b0; src1_req = 1'b1;
      pulse_tick();
      wait_valid(found);
      check("rst_run_reached", 64'(found), 64'd1);
      reset = 1'b1;
      cyc();
      check("rst_run_ctrl", 64'(ctrl_bits()), 64'd0);
      check("rst_run_dout", 64'(out_dout), 64'd0);
      reset = 1'b0;
      exp_q.delete(); exp_total = 0;
      cyc();

      // After reset, alternate mode starts from src0 again.
      mode = MODE_ALT; src0_req = 1'b1; src1_req = 1'b1; owner_log.delete();
      pulse_tick();
      repeat (GAP) cyc();
      check("post_rst_frame_count", 64'(owner_log.size()), 64'd1);
      if (owner_log.size() > 0) check("post_rst_owner", 64'(owner_log[0]), 64'd0);
      check("post_rst_frames_done", 64'(frames_done), 64'd1);
      check("post_rst_beats_left", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
